// File: rtl/sparse_mem_pkg.sv
// rtl/sparse_mem_pkg.sv - shared types and widths for the sparse matrix memory controller
package sparse_mem_pkg;

    localparam int BYTE_W  = 8;
    localparam int ENTRY_W = 16;
    localparam int ADDR_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_HI = 2'd1,
        LOAD_LO = 2'd2,
        SERVE   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a single priority bit
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = prio ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    // Whoever was just served yields priority to the other port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (grant[0]) begin
            prio <= 1'b1;
        end else if (grant[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/sparse_mem_ctrl.sv
// rtl/sparse_mem_ctrl.sv - byte-stream loader and two-port read arbiter for the sparse multiplier memory
module sparse_mem_ctrl #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic              load_err,
    output logic              busy,
    input  logic [1:0]        rd_req,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [1:0]        rd_grant,
    output logic [1:0]        rd_valid,
    output logic [15:0]       rd_data,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_write_ptr,
    output logic [ADDR_W-1:0] mem_read_ptr,
    output logic [7:0]        mem_in_data,
    input  logic [127:0]      mem_out_data
);

    import sparse_mem_pkg::*;

    ctrl_state_t       state, state_nx;
    logic [ADDR_W-1:0] wptr, wptr_nx;
    logic [ADDR_W-1:0] count, count_nx;
    logic [ADDR_W-1:0] loaded, loaded_nx;
    logic [ADDR_W-1:0] rptr_q;
    logic [ADDR_W-1:0] grant_addr;
    logic              load_done_nx, load_err_nx;
    logic              count_ok;
    logic              oor_q;
    logic              unused_mem_hi;

    assign unused_mem_hi = ^mem_out_data[127:ENTRY_W];

    assign count_ok = (load_count != '0) && (32'(load_count) <= 32'(ENTRIES));

    always_comb begin
        state_nx     = state;
        wptr_nx      = wptr;
        count_nx     = count;
        loaded_nx    = loaded;
        load_done_nx = 1'b0;
        load_err_nx  = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE, SERVE: begin
                if (load_start) begin
                    if (count_ok) begin
                        count_nx  = load_count;
                        wptr_nx   = '0;
                        loaded_nx = '0;
                        state_nx  = LOAD_HI;
                    end else begin
                        load_err_nx = 1'b1;
                        state_nx    = IDLE;
                    end
                end
            end
            LOAD_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    state_nx = LOAD_LO;
                end
            end
            LOAD_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (wptr == count - ADDR_W'(1)) begin
                        loaded_nx    = count;
                        load_done_nx = 1'b1;
                        state_nx     = SERVE;
                    end else begin
                        wptr_nx  = wptr + ADDR_W'(1);
                        state_nx = LOAD_HI;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Both bytes of an entry go to the same pointer; the memory shifts them in.
    assign mem_wen       = in_valid & in_ready;
    assign mem_in_data   = in_data;
    assign mem_write_ptr = wptr;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (rd_req),
        .enable (state == SERVE),
        .grant  (rd_grant)
    );

    assign grant_addr   = rd_grant[1] ? rd_addr1 : rd_addr0;
    assign mem_read_ptr = (|rd_grant) ? grant_addr : rptr_q;

    // The memory output is registered, so data lines up with rd_valid one cycle after grant.
    assign rd_data = ((|rd_valid) && !oor_q) ? mem_out_data[ENTRY_W-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wptr      <= '0;
            count     <= '0;
            loaded    <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            rd_valid  <= 2'b00;
            oor_q     <= 1'b0;
            rptr_q    <= '0;
        end else begin
            state     <= state_nx;
            wptr      <= wptr_nx;
            count     <= count_nx;
            loaded    <= loaded_nx;
            load_done <= load_done_nx;
            load_err  <= load_err_nx;
            rd_valid  <= rd_grant;
            rptr_q    <= mem_read_ptr;
            if (|rd_grant) begin
                oor_q <= (grant_addr >= loaded);
            end
        end
    end

endmodule

// File: tb/tb_sparse_mem_ctrl.sv
// tb/tb_sparse_mem_ctrl.sv - self-checking bench for sparse_mem_ctrl
module tb_sparse_mem_ctrl;

    localparam int ENTRIES = 64;
    localparam int ADDR_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_count = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, load_done, load_err, busy;
    logic [1:0]        rd_req = 2'b00;
    logic [ADDR_W-1:0] rd_addr0 = '0;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [1:0]        rd_grant, rd_valid;
    logic [15:0]       rd_data;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_write_ptr, mem_read_ptr;
    logic [7:0]        mem_in_data;
    logic [127:0]      mem_out_data;

    sparse_mem_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_count    (load_count),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .load_done     (load_done),
        .load_err      (load_err),
        .busy          (busy),
        .rd_req        (rd_req),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_grant      (rd_grant),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .mem_wen       (mem_wen),
        .mem_write_ptr (mem_write_ptr),
        .mem_read_ptr  (mem_read_ptr),
        .mem_in_data   (mem_in_data),
        .mem_out_data  (mem_out_data)
    );

    always #5 clk = ~clk;

    // Byte-shift memory with registered output; reset fills it with junk so unloaded reads are visible.
    logic [15:0] mem [0:ENTRIES-1];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= 16'hD000 | 16'(i + 1);
            mem_out_data <= '0;
        end else begin
            if (mem_wen) mem[mem_write_ptr[5:0]] <= {mem[mem_write_ptr[5:0]][7:0], mem_in_data};
            mem_out_data <= {112'b0, mem[mem_read_ptr[5:0]]};
        end
    end

    int n_vec  = 0;
    int n_miss = 0;
    int wen_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] exp_mem [0:ENTRIES-1];
    int          exp_loaded = 0;

    typedef struct {
        int          port;
        logic [15:0] data;
    } sb_t;
    sb_t sb[$];
    sb_t sb_e;
    logic [ADDR_W-1:0] g_addr;

    // Scoreboard: expectation pushed at grant, popped when rd_valid appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'h0);
                end else begin
                    sb_e = sb.pop_front();
                    check("rd_valid_port", 32'(rd_valid), 32'(2'b01 << sb_e.port));
                    check("rd_data", 32'(rd_data), 32'(sb_e.data));
                end
            end
            if (mem_wen) wen_count++;
            if (rd_grant != 2'b00) begin
                g_addr    = rd_grant[1] ? rd_addr1 : rd_addr0;
                sb_e.port = rd_grant[1] ? 1 : 0;
                sb_e.data = (int'(g_addr) < exp_loaded) ? exp_mem[g_addr[5:0]] : 16'h0000;
                sb.push_back(sb_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] b, input int ptr);
        in_valid = 1'b1;
        in_data  = b;
        #2;
        check("load_wen", 32'(mem_wen), 32'h1);
        check("load_wptr", 32'(mem_write_ptr), 32'(ptr));
        check("load_wdata", 32'(mem_in_data), 32'(b));
        check("load_done_early", 32'(load_done), 32'h0);
        step();
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [1:0]  grant;
        logic [15:0] rptr;
    } vec_t;
    vec_t vt[11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{2'b01, 16'd0, 16'd9, 2'b01, 16'd0};
        vt[1]  = '{2'b10, 16'd9, 16'd1, 2'b10, 16'd1};
        vt[2]  = '{2'b11, 16'd0, 16'd2, 2'b01, 16'd0};
        vt[3]  = '{2'b11, 16'd0, 16'd2, 2'b10, 16'd2};
        vt[4]  = '{2'b11, 16'd0, 16'd2, 2'b01, 16'd0};
        vt[5]  = '{2'b11, 16'd0, 16'd2, 2'b10, 16'd2};
        vt[6]  = '{2'b00, 16'd7, 16'd8, 2'b00, 16'd2};
        vt[7]  = '{2'b10, 16'd0, 16'd5, 2'b10, 16'd5};
        vt[8]  = '{2'b01, 16'd3, 16'd0, 2'b01, 16'd3};
        vt[9]  = '{2'b11, 16'd2, 16'd1, 2'b10, 16'd1};
        vt[10] = '{2'b01, 16'd0, 16'd0, 2'b01, 16'd0};
        for (int i = 0; i < ENTRIES; i++) exp_mem[i] = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #3;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(rd_grant), 32'h0);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_wen", 32'(mem_wen), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rptr", 32'(mem_read_ptr), 32'h0);
        check("rst_wptr", 32'(mem_write_ptr), 32'h0);
        check("rst_done_err", 32'({load_done, load_err}), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Illegal counts at both ends of the range
        for (int k = 0; k < 2; k++) begin
            load_start = 1'b1;
            load_count = (k == 0) ? 16'd0 : 16'(ENTRIES + 1);
            step();
            load_start = 1'b0;
            check("err_pulse", 32'(load_err), 32'h1);
            check("err_busy", 32'(busy), 32'h0);
            check("err_in_ready", 32'(in_ready), 32'h0);
            step();
            check("err_pulse_end", 32'(load_err), 32'h0);
        end
        check("err_no_writes", 32'(wen_count), 32'h0);

        // Load three entries with a two-cycle stall inside LOAD_LO
        load_start = 1'b1;
        load_count = 16'd3;
        step();
        load_start = 1'b0;
        check("load_busy", 32'(busy), 32'h1);
        check("load_in_ready", 32'(in_ready), 32'h1);
        feed(8'h12, 0);
        feed(8'h34, 0);
        feed(8'h56, 1);
        for (int g = 0; g < 2; g++) begin
            #2;
            check("stall_wen", 32'(mem_wen), 32'h0);
            check("stall_busy", 32'(busy), 32'h1);
            step();
        end
        feed(8'h78, 1);
        feed(8'h9A, 2);
        feed(8'hBC, 2);
        check("load_done", 32'(load_done), 32'h1);
        check("serve_busy", 32'(busy), 32'h0);
        step();
        check("load_done_end", 32'(load_done), 32'h0);
        check("load_write_count", 32'(wen_count), 32'd6);
        exp_mem[0] = 16'h1234;
        exp_mem[1] = 16'h5678;
        exp_mem[2] = 16'h9ABC;
        exp_loaded = 3;

        // Arbitration table
        for (int i = 0; i < 11; i++) begin
            rd_req   = vt[i].req;
            rd_addr0 = vt[i].a0;
            rd_addr1 = vt[i].a1;
            #2;
            check($sformatf("vec%0d_grant", i), 32'(rd_grant), 32'(vt[i].grant));
            check($sformatf("vec%0d_rptr", i), 32'(mem_read_ptr), 32'(vt[i].rptr));
            step();
        end
        rd_req = 2'b00;
        step();
        step();
        check("sb_drained_table", 32'(sb.size()), 32'h0);

        // Grant in the same cycle as load_start, then no grants while loading
        rd_req     = 2'b01;
        rd_addr0   = 16'd1;
        load_start = 1'b1;
        load_count = 16'd1;
        #2;
        check("ls_grant", 32'(rd_grant), 32'h1);
        step();
        load_start = 1'b0;
        rd_req     = 2'b11;
        check("ls_busy", 32'(busy), 32'h1);
        check("ls_valid", 32'(rd_valid), 32'h1);
        #2;
        check("ls_no_grant_hi", 32'(rd_grant), 32'h0);
        step();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #2;
        check("ls_no_grant_hi2", 32'(rd_grant), 32'h0);
        step();
        in_data = 8'h55;
        #2;
        check("ls_no_grant_lo", 32'(rd_grant), 32'h0);
        step();
        in_valid = 1'b0;
        rd_req   = 2'b00;
        check("ls_load_done", 32'(load_done), 32'h1);
        exp_mem[0] = 16'hAA55;
        exp_loaded = 1;
        rd_req   = 2'b01;
        rd_addr0 = 16'd0;
        #2;
        check("ls_read0_grant", 32'(rd_grant), 32'h1);
        step();
        rd_req   = 2'b10;
        rd_addr1 = 16'd1;
        #2;
        check("ls_read1_grant", 32'(rd_grant), 32'h2);
        step();
        rd_req = 2'b00;
        step();
        step();
        check("sb_drained_ls", 32'(sb.size()), 32'h0);

        // Reset in the middle of LOAD_LO
        load_start = 1'b1;
        load_count = 16'd2;
        step();
        load_start = 1'b0;
        feed(8'h11, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_grant", 32'(rd_grant), 32'h0);
        step();
        reset  = 1'b0;
        rd_req = 2'b01;
        #2;
        check("mid_rst_req_no_grant", 32'(rd_grant), 32'h0);
        step();
        check("mid_rst_no_valid", 32'(rd_valid), 32'h0);
        rd_req = 2'b00;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
